// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - memory-mapped control front-end for the countdown timer
module timer_ctrl (
   input  logic        clk_10M,
   input  logic        rst,
   input  logic        we_i,
   input  logic        re_i,
   input  logic [3:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        rvalid_o,
   output logic        load_o,
   output logic [31:0] data_o,
   input  logic [31:0] cuenta_i,
   output logic        irq_o
);

   localparam logic [1:0] SEL_LOAD   = 2'd0;
   localparam logic [1:0] SEL_COUNT  = 2'd1;
   localparam logic [1:0] SEL_STATUS = 2'd2;
   localparam logic [1:0] SEL_CTRL   = 2'd3;

   logic [31:0] r_reload;
   logic [31:0] r_prev;
   logic        r_done;
   logic [7:0]  r_exp_cnt;
   logic        r_irq_en;
   logic        r_auto_reload;
   logic        r_load;
   logic [31:0] r_data;
   logic [31:0] r_rdata;
   logic        r_rvalid;

   logic [1:0]  w_sel;
   logic        w_wr_load;
   logic        w_wr_status;
   logic        w_wr_ctrl;
   logic        w_expire;
   logic        w_auto_req;
   logic        w_running;
   logic        w_done_clr;
   logic        w_cnt_clr;
   logic [31:0] w_rd_mux;
   logic        w_unused_addr;

   // Byte-offset low bits carry no information for word registers
   assign w_unused_addr = ^addr_i[1:0];

   assign w_sel       = addr_i[3:2];
   assign w_wr_load   = we_i && (w_sel == SEL_LOAD);
   assign w_wr_status = we_i && (w_sel == SEL_STATUS);
   assign w_wr_ctrl   = we_i && (w_sel == SEL_CTRL);
   assign w_done_clr  = w_wr_status && wdata_i[0];
   assign w_cnt_clr   = w_wr_status && wdata_i[2];

   // Expiry is a falling transition into zero; a count idling at zero never fires
   assign w_expire    = (r_prev != 32'd0) && (cuenta_i == 32'd0);
   assign w_auto_req  = w_expire && r_auto_reload;
   assign w_running   = (cuenta_i != 32'd0);

   // A reset arriving while a pulse is pending suppresses it immediately
   assign load_o   = r_load && rst;
   assign data_o   = r_data;
   assign rdata_o  = r_rdata;
   assign rvalid_o = r_rvalid;
   assign irq_o    = r_done && r_irq_en;

   // Read data selection from current register state and live count
   always_comb begin
      w_rd_mux = 32'd0;
      case (w_sel)
         SEL_LOAD:   w_rd_mux = r_reload;
         SEL_COUNT:  w_rd_mux = cuenta_i;
         SEL_STATUS: w_rd_mux = {16'd0, r_exp_cnt, 6'd0, w_running, r_done};
         SEL_CTRL:   w_rd_mux = {30'd0, r_auto_reload, r_irq_en};
         default:    w_rd_mux = 32'd0;
      endcase
   end

   // Previous-count tracker used for expiry edge detection
   always_ff @(posedge clk_10M) begin
      if (!rst) r_prev <= 32'd0;
      else      r_prev <= cuenta_i;
   end

   // Reload value and control bits written by the processor
   always_ff @(posedge clk_10M) begin
      if (!rst) begin
         r_reload      <= 32'd0;
         r_irq_en      <= 1'b0;
         r_auto_reload <= 1'b0;
      end else begin
         if (w_wr_load) r_reload <= wdata_i;
         if (w_wr_ctrl) begin
            r_irq_en      <= wdata_i[0];
            r_auto_reload <= wdata_i[1];
         end
      end
   end

   // Load pulse generation; a CPU write takes priority over auto-reload
   always_ff @(posedge clk_10M) begin
      if (!rst) begin
         r_load <= 1'b0;
         r_data <= 32'd0;
      end else begin
         r_load <= w_wr_load || w_auto_req;
         if (w_wr_load)       r_data <= wdata_i;
         else if (w_auto_req) r_data <= r_reload;
      end
   end

   // Sticky done flag; setting by expiry beats a simultaneous clear
   always_ff @(posedge clk_10M) begin
      if (!rst)             r_done <= 1'b0;
      else if (w_expire)    r_done <= 1'b1;
      else if (w_done_clr)  r_done <= 1'b0;
   end

   // Saturating expiry counter; clear plus expiry in one cycle yields 1
   always_ff @(posedge clk_10M) begin
      if (!rst)                               r_exp_cnt <= 8'd0;
      else if (w_cnt_clr)                     r_exp_cnt <= w_expire ? 8'd1 : 8'd0;
      else if (w_expire && r_exp_cnt != 8'hFF) r_exp_cnt <= r_exp_cnt + 8'd1;
   end

   // Registered read response; data holds until the next read
   always_ff @(posedge clk_10M) begin
      if (!rst) begin
         r_rdata  <= 32'd0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= re_i;
         if (re_i) r_rdata <= w_rd_mux;
      end
   end

endmodule
